mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Two-requester arbiter that shares the single-port 2048×16 program/data memory between the CPU fetch/execute port (port 0) and a DMA/program-loader port (port 1). It accepts one transaction at a time and drives the memory read/write strobes, address and write data. It returns read data with a one-cycle acknowledge pulse to the granted requester. It sits between the requesters and the memory, in place of the CPU's direct `memoryRead`/`memoryWrite` connection.

## Interface
Parameters:
- `ADDR_W`, 11: address width; matches the CPU's PC and MAR.
- `DATA_W`, 16: data width.
- `MEM_LAT`, 2: number of clock edges from the rising edge that asserts a read strobe to the edge that samples `mem_rdata`. Must be ≥ 2.

Ports (one clock; reset is asynchronous and active-high):
- `clock`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req0` / `req1`  in  1  request from port 0 / port 1.
- `we0` / `we1`  in  1  1 = write, 0 = read.
- `addr0` / `addr1`  in  ADDR_W  transaction address.
- `wdata0` / `wdata1`  in  DATA_W  write data.
- `ack0` / `ack1`  out  1  one-cycle completion pulse.
- `rdata0` / `rdata1`  out  DATA_W  read data; valid while ack is high and held until the next read on that port.
- `mem_read`  out  1  memory read strobe.
- `mem_write`  out  1  memory write strobe.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data.
- `busy`  out  1  high in every state except IDLE.
- `owner`  out  1  index of the port granted most recently.

## Operation
FSM states:
- **IDLE**
  - If any req is high, grant a port, latch its `we`/`addr`/`wdata`, go to ACCESS.
  - Otherwise stay in IDLE.
- **ACCESS**
  - Drive `mem_read` (read) or `mem_write` (write) for exactly one cycle.
  - `mem_addr` and `mem_wdata` come from the latched values.
  - Read → WAIT. Write → DONE.
- **WAIT**
  - Down-counter loaded with `MEM_LAT-1`; decrements each cycle.
  - On the cycle the count reaches 1, sample `mem_rdata` into the granted port's `rdata` register and go to DONE.
- **DONE**
  - Pulse the granted port's ack for one cycle, then go to IDLE.

Arbitration:
- One request only: grant that port.
- Both requesting in IDLE: grant the port ≠ `last_owner` (round-robin).
- `last_owner` resets to 1, so port 0 (CPU) wins the first tie.
- `owner` output = `last_owner`, updated at grant.

Handshake rules:
- The requester holds req, `we`, `addr` and `wdata` stable until it sees ack.
- Request fields are latched at grant. Changing them or dropping req after grant does not affect the transaction; it completes and still acks.
- A req that is high in IDLE, i.e. the cycle after ack, is a new request.
- The non-granted port's req is ignored until the next IDLE, with no loss: the requester just keeps req high.

Other behaviour:
- `mem_read` and `mem_write` are never high together and are never high outside ACCESS.
- Address and data pass through unchanged. There is no wrap, no arithmetic and no range check: all 2^ADDR_W addresses are legal.
- Reset (asynchronous, at any time, including mid-transaction):
  - state → IDLE, `last_owner` → 1.
  - All outputs → 0: strobes, `mem_addr`, `mem_wdata`, acks, both rdata, `busy`, `owner`.
  - An aborted transaction is never acked; the requester re-issues it.

## Timing
- Request sampled high in IDLE at cycle T.
- Read: strobe in T+1, `mem_rdata` sampled at the end of cycle T+MEM_LAT, ack + rdata in T+MEM_LAT+1. Default: ack in T+3, 4 cycles per read.
- Write: strobe + data in T+1, ack in T+2. 3 cycles per write.
- Minimum 1 IDLE cycle between transactions.
- Port-0 worst-case wait with port 1 continuously requesting: one port-1 transaction.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `cpu_mem_pkg`:
  - `ADDR_W` and `DATA_W` constants.
  - `arb_state_t` enum {IDLE, ACCESS, WAIT, DONE}.
  - `PORT_CPU` = 0, `PORT_DMA` = 1 constants.
- One natural sub-module: `mem_rr_picker`.
  - Combinational 2-way round-robin.
  - Inputs `req0`, `req1`, `last_owner`; outputs `grant_valid`, `grant_idx`.
  - Instantiated once.

## Test plan
- Port-0 read at addr 0x005, memory model returns 0xBEEF two edges after the strobe → `mem_read` high for exactly one cycle, `ack0` in T+3, `rdata0` = 0xBEEF, `ack1` stays 0.
- Port-1 write of 0x1234 to 0x7FF → `mem_write` + `mem_addr` 0x7FF + `mem_wdata` 0x1234 in T+1, `ack1` in T+2, `mem_read` never asserts.
- Both ports request reads continuously from reset → grants alternate 0,1,0,1; each ack 4 cycles apart; `owner` toggles accordingly.
- Port 0 changes `addr0` and drops `req0` one cycle after grant → memory still sees the original address; `ack0` still pulses.
- Reset asserted during WAIT → strobes, acks and `busy` go to 0 immediately; no ack follows; the first request after reset is granted normally.
- `MEM_LAT` = 4 build, port-0 read → `mem_rdata` sampled at T+4, `ack0` at T+5.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// ---------------------------------------------------------------------------
// cpu_mem_pkg
//   Shared definitions for the CPU/DMA memory port arbiter.
//   - ADDR_W / DATA_W : default address and data widths of the shared
//                       2048x16 program/data memory.
//   - PORT_CPU/PORT_DMA : requester indices.
//   - arb_state_t      : arbiter FSM states.
//   - rr_pick()        : 2-way round-robin choice used by mem_rr_picker.
// ---------------------------------------------------------------------------
package cpu_mem_pkg;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 16;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

  // Index of the winning port. On a tie the port that was NOT served last
  // wins; with a single requester that requester wins. The result is only
  // meaningful when at least one request is present.
  function automatic logic rr_pick(input logic req0,
                                   input logic req1,
                                   input logic last_owner);
    logic idx;
    if (req0 && req1) begin
      idx = ~last_owner;
    end else if (req1) begin
      idx = PORT_DMA;
    end else begin
      idx = PORT_CPU;
    end
    return idx;
  endfunction

endpackage

// File: rtl/mem_rr_picker.sv
// ---------------------------------------------------------------------------
// mem_rr_picker
//   Combinational 2-way round-robin picker.
//   Ports:
//     req0, req1   in   requests from port 0 / port 1
//     last_owner   in   port granted most recently
//     grant_valid  out  at least one request present
//     grant_idx    out  index of the port to grant (valid with grant_valid)
// ---------------------------------------------------------------------------
module mem_rr_picker
  import cpu_mem_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_owner,
  output logic grant_valid,
  output logic grant_idx
);

  assign grant_valid = req0 | req1;
  assign grant_idx   = rr_pick(req0, req1, last_owner);

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-port memory between the CPU (port 0) and a DMA /
//   program loader (port 1). One transaction at a time:
//     IDLE -> ACCESS (one-cycle strobe) -> [WAIT for reads] -> DONE (ack).
//   Ports:
//     clock, reset           clock, asynchronous active-high reset
//     req/we/addr/wdata 0,1  requester side transaction fields
//     ack0, ack1             one-cycle completion pulse
//     rdata0, rdata1         read data, held until the next read on the port
//     mem_read, mem_write    memory strobes (exactly one ACCESS cycle)
//     mem_addr, mem_wdata    memory address / write data
//     mem_rdata              memory read data
//     busy                   high in every state except IDLE
//     owner                  port granted most recently (0 after reset)
//   Every output comes straight from a register.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W  = cpu_mem_pkg::ADDR_W,
  parameter int DATA_W  = cpu_mem_pkg::DATA_W,
  parameter int MEM_LAT = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  import cpu_mem_pkg::*;

  // WAIT counter holds MEM_LAT-1 down to 1.
  localparam int CNT_W = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;

  // ---------------------------------------------------------------------
  // Per-port request fields gathered into vectors so the granted port can
  // be selected by index.
  // ---------------------------------------------------------------------
  logic [1:0]        req_vec;
  logic [1:0]        we_vec;
  logic [ADDR_W-1:0] addr_arr  [2];
  logic [DATA_W-1:0] wdata_arr [2];

  assign req_vec      = {req1, req0};
  assign we_vec       = {we1, we0};
  assign addr_arr[0]  = addr0;
  assign addr_arr[1]  = addr1;
  assign wdata_arr[0] = wdata0;
  assign wdata_arr[1] = wdata1;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  arb_state_t        state_reg;
  logic              last_owner_reg;
  logic              owner_reg;
  logic              port_reg;       // port of the transaction in flight
  logic              we_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              mem_read_reg;
  logic              mem_write_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [DATA_W-1:0] mem_wdata_reg;
  logic              busy_reg;

  logic grant_valid;
  logic grant_idx;

  mem_rr_picker u_picker (
    .req0        (req_vec[0]),
    .req1        (req_vec[1]),
    .last_owner  (last_owner_reg),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Last WAIT cycle: mem_rdata is sampled on the closing edge.
  logic rdata_load;
  // Edge that moves the FSM into DONE: the ack register rises on it so the
  // ack pulse coincides with the DONE cycle.
  logic ack_fire;

  assign rdata_load = (state_reg == WAIT) && (cnt_reg == CNT_W'(1));
  assign ack_fire   = rdata_load || ((state_reg == ACCESS) && we_reg);

  // ---------------------------------------------------------------------
  // Arbiter FSM. Strobes default low each cycle so they can only be high
  // for the single ACCESS cycle that follows a grant.
  // ---------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      last_owner_reg <= PORT_DMA;  // CPU wins the first tie
      owner_reg      <= PORT_CPU;
      port_reg       <= PORT_CPU;
      we_reg         <= 1'b0;
      cnt_reg        <= '0;
      mem_read_reg   <= 1'b0;
      mem_write_reg  <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      busy_reg       <= 1'b0;
    end else begin
      mem_read_reg  <= 1'b0;
      mem_write_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (grant_valid) begin
            // Fields are captured here; the requester may change or drop
            // them afterwards without affecting this transaction.
            port_reg       <= grant_idx;
            last_owner_reg <= grant_idx;
            owner_reg      <= grant_idx;
            we_reg         <= we_vec[grant_idx];
            mem_addr_reg   <= addr_arr[grant_idx];
            mem_wdata_reg  <= wdata_arr[grant_idx];
            mem_read_reg   <= ~we_vec[grant_idx];
            mem_write_reg  <= we_vec[grant_idx];
            busy_reg       <= 1'b1;
            state_reg      <= ACCESS;
          end
        end
        ACCESS: begin
          if (we_reg) begin
            state_reg <= DONE;
          end else begin
            cnt_reg   <= CNT_W'(MEM_LAT - 1);
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_reg == CNT_W'(1)) begin
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        DONE: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Per-port ack pulse and read-data holding register.
  // ---------------------------------------------------------------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic              ack_q;
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        ack_q   <= 1'b0;
        rdata_q <= '0;
      end else begin
        ack_q <= ack_fire && (port_reg == 1'(gi));
        if (rdata_load && (port_reg == 1'(gi))) begin
          rdata_q <= mem_rdata;
        end
      end
    end
  end

  assign ack0      = g_port[0].ack_q;
  assign ack1      = g_port[1].ack_q;
  assign rdata0    = g_port[0].rdata_q;
  assign rdata1    = g_port[1].rdata_q;
  assign mem_read  = mem_read_reg;
  assign mem_write = mem_write_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign busy      = busy_reg;
  // owner tracks last_owner but has its own register because it must read
  // 0 after reset while last_owner resets to 1.
  assign owner     = owner_reg;

endmodule
